sync_debounce_array: RTL and testbench

//  Parametrised multi-channel input conditioner: per channel, an N-stage synchroniser feeds a saturating-count debouncer.

---
 rtl/sync_debounce_array_pkg.sv | 13 +
 rtl/sync_debounce_array_debounce_channel.sv | 61 ++++++
 rtl/sync_debounce_array.sv | 50 +++++
 tb/tb_sync_debounce_array.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_debounce_array_pkg.sv
// Shared constants and helpers for the multi-channel synchroniser/debouncer.
// Imported by the per-channel block and the array top.
package sync_debounce_array_pkg;

  // Idle level of open-drain style buses (SCL/SDA) and pulled-up straps.
  localparam logic IDLE_HIGH = 1'b1;

  // Width of a counter that must hold values 0 .. cycles-1 without wrapping.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_array_debounce_channel.sv
// One input channel: N-flop synchroniser, saturating-count debouncer and
// registered single-cycle rise/fall pulses on the accepted level.
module debounce_channel
  import sync_debounce_array_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 3,
  parameter logic RESET_VALUE     = IDLE_HIGH
) (
  input  logic control_clock,
  input  logic control_reset_n,
  input  logic enable,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   synced;

  // NOTE: non-blocking assignments let every stage sample its neighbour's
  // pre-edge value; blocking ones would collapse the chain into one flop.
  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // cnt == 0 is the stable state, cnt > 0 means a new level is being qualified.
  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      level <= RESET_VALUE;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!enable || (synced == level)) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
        rise  <= synced;
        fall  <= ~synced;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_debounce_array.sv
// Multi-channel input conditioner: independent sync+debounce per channel,
// with per-channel edge pulses and a combined any_change flag.
module sync_debounce_array
  import sync_debounce_array_pkg::*;
#(
  parameter int   CHANNELS        = 2,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 3,
  parameter logic RESET_VALUE     = IDLE_HIGH
) (
  input  logic                control_clock,
  input  logic                control_reset_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] input_data,
  output logic [CHANNELS-1:0] output_data,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("sync_debounce_array: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_debounce_array: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sync_debounce_array: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (RESET_VALUE)
    ) u_ch (
      .control_clock  (control_clock),
      .control_reset_n(control_reset_n),
      .enable         (enable),
      .raw            (input_data[i]),
      .level          (output_data[i]),
      .rise           (rise_pulse[i]),
      .fall           (fall_pulse[i])
    );
  end

  // Pulses are already registered, so this OR stays glitch-free for consumers.
  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_debounce_array.sv
// Directed bench: default 2-channel instance checked through an event
// scoreboard, plus a 4-channel/3-stage/1-cycle instance checked directly.
module tb_sync_debounce_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] din_a;
  logic [1:0] out_a, rise_a, fall_a;
  logic       any_a;
  logic [3:0] din_b;
  logic [3:0] out_b, rise_b, fall_b;
  logic       any_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_debounce_array u_dut_a (
    .control_clock  (clk),
    .control_reset_n(rst_n),
    .enable         (enable),
    .input_data     (din_a),
    .output_data    (out_a),
    .rise_pulse     (rise_a),
    .fall_pulse     (fall_a),
    .any_change     (any_a)
  );

  sync_debounce_array #(
    .CHANNELS       (4),
    .SYNC_STAGES    (3),
    .DEBOUNCE_CYCLES(1)
  ) u_dut_b (
    .control_clock  (clk),
    .control_reset_n(rst_n),
    .enable         (enable),
    .input_data     (din_b),
    .output_data    (out_b),
    .rise_pulse     (rise_b),
    .fall_pulse     (fall_b),
    .any_change     (any_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pulse event for instance A, lat edges after the next capture edge's predecessor.
  task automatic push_exp(input int lat, input logic [1:0] o, input logic [1:0] r,
                          input logic [1:0] f);
    exp_t e;
    e.cyc  = cyc + lat;
    e.out  = o;
    e.rise = r;
    e.fall = f;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: every pulse on A must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 || rst_n === 1'b0) begin
      check("a_any_is_or", any_a, |(rise_a | fall_a));
      check("a_rise_fall_excl", rise_a & fall_a, 0);
    end
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      check("a_missed_pulse_cyc", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (any_a === 1'b1) begin
      if (sb.size() == 0) begin
        check("a_unexpected_pulse", any_a, 0);
      end else begin
        e = sb.pop_front();
        check("a_pulse_cyc", cyc, e.cyc);
        check("a_pulse_out", out_a, e.out);
        check("a_pulse_rise", rise_a, e.rise);
        check("a_pulse_fall", fall_a, e.fall);
      end
    end
  end

  initial begin
    // Reset with inputs low: outputs must sit at the idle-high reset level.
    rst_n  = 1'b0;
    enable = 1'b1;
    din_a  = 2'b00;
    din_b  = 4'h0;
    tick(4);
    check("rst_out_a", out_a, 2'b11);
    check("rst_rise_a", rise_a, 2'b00);
    check("rst_fall_a", fall_a, 2'b00);
    check("rst_any_a", any_a, 1'b0);
    check("rst_out_b", out_b, 4'hF);
    check("rst_any_b", any_b, 1'b0);
    din_a = 2'b11;
    din_b = 4'hF;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("rst_exit_any_a", any_a, 1'b0);
    check("rst_exit_any_b", any_b, 1'b0);
    tick(8);
    check("idle_out_a", out_a, 2'b11);

    // Held fall on ch0: accepted on the 5th edge from capture, pulse one cycle.
    push_exp(5, 2'b10, 2'b00, 2'b01);
    din_a = 2'b10;
    tick(4);
    check("lat_before_out", out_a, 2'b11);
    tick(1);
    check("lat_at_out", out_a, 2'b10);
    check("lat_at_fall", fall_a, 2'b01);
    check("lat_at_any", any_a, 1'b1);
    tick(1);
    check("lat_after_fall", fall_a, 2'b00);

    // 2-cycle glitch on ch1 is rejected.
    tick(4);
    din_a = 2'b00;
    tick(2);
    din_a = 2'b10;
    tick(8);
    check("glitch2_out", out_a, 2'b10);

    // 3-cycle low on ch1 is accepted, then the return high is accepted too.
    push_exp(5, 2'b00, 2'b00, 2'b10);
    push_exp(8, 2'b10, 2'b10, 2'b00);
    din_a = 2'b00;
    tick(3);
    din_a = 2'b10;
    tick(12);
    check("glitch3_out", out_a, 2'b10);

    // Raise ch0, chatter it, then settle low.
    push_exp(5, 2'b11, 2'b01, 2'b00);
    din_a = 2'b11;
    tick(10);
    for (int i = 0; i < 5; i++) begin
      din_a = 2'b10;
      tick(2);
      din_a = 2'b11;
      tick(2);
    end
    check("chatter_out", out_a, 2'b11);
    push_exp(5, 2'b10, 2'b00, 2'b01);
    din_a = 2'b10;
    tick(10);
    check("chatter_settle_out", out_a, 2'b10);

    // enable dropped with cnt==2: nothing accepted; re-enable restarts from 0.
    din_a = 2'b11;
    tick(4);
    enable = 1'b0;
    tick(6);
    check("disabled_out", out_a, 2'b10);
    push_exp(3, 2'b11, 2'b01, 2'b00);
    enable = 1'b1;
    tick(2);
    check("reenable_early_out", out_a, 2'b10);
    tick(1);
    check("reenable_out", out_a, 2'b11);
    check("reenable_rise", rise_a, 2'b01);
    tick(4);

    // Reset mid-count on ch1: count restarts from scratch after release.
    din_a = 2'b01;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    check("midrst_out", out_a, 2'b11);
    check("midrst_any", any_a, 1'b0);
    push_exp(5, 2'b01, 2'b00, 2'b10);
    rst_n = 1'b1;
    tick(1);
    check("midrst_exit_any", any_a, 1'b0);
    tick(9);
    check("midrst_accept_out", out_a, 2'b01);
    push_exp(5, 2'b11, 2'b10, 2'b00);
    din_a = 2'b11;
    tick(8);

    // Instance B: 3 sync stages + 1 debounce cycle -> 4 edges inclusive.
    din_b = 4'h0;
    tick(3);
    check("b_fall_early_out", out_b, 4'hF);
    check("b_fall_early_any", any_b, 1'b0);
    tick(1);
    check("b_fall_out", out_b, 4'h0);
    check("b_fall_pulse", fall_b, 4'hF);
    check("b_fall_rise", rise_b, 4'h0);
    tick(1);
    check("b_fall_clear", fall_b, 4'h0);
    din_b = 4'hF;
    tick(3);
    check("b_rise_early", rise_b, 4'h0);
    tick(1);
    check("b_rise_pulse", rise_b, 4'hF);
    check("b_rise_out", out_b, 4'hF);
    check("b_rise_any", any_b, 1'b1);
    tick(1);
    check("b_rise_clear", rise_b, 4'h0);
    check("b_rise_any_clear", any_b, 1'b0);
    din_b = 4'b0101;
    tick(4);
    check("b_mixed_out", out_b, 4'b0101);
    check("b_mixed_fall", fall_b, 4'b1010);
    check("b_mixed_rise", rise_b, 4'b0000);

    tick(2);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
